// File: rtl/seg_scan_decode.sv
// Recovers hex digits from a multiplexed active-low segment/select bus; optional SEG_DP_EN includes dp in compare.
// Latency: event valid 2 cycles after the STABLE-th matching selected sample when the output is idle.
// Backpressure: output register holds while o_vld & !i_rdy; commits queue as per-digit dirty flags.
module seg_scan_decode #(
  parameter int NDIG   = 2,
  parameter int STABLE = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      i_seg,
  input  logic [NDIG-1:0] i_dig,
  output logic            o_vld,
  input  logic            i_rdy,
  output logic [2:0]      o_idx,
  output logic [3:0]      o_hex,
  output logic            o_err,
  output logic            o_dp
);

  localparam logic [3:0] STABLE_C = 4'(STABLE);

  logic [7:0]      raw;
  logic [NDIG-1:0] sel;
  logic            sel_vld;

  logic [7:0]      cand_q [NDIG];
  logic [3:0]      cnt_q  [NDIG];
  logic [7:0]      comm_q [NDIG];
  logic [NDIG-1:0] dirty_q;

  logic [3:0]      cnt_upd [NDIG];
  logic [NDIG-1:0] commit;
  logic [NDIG-1:0] dirty_nxt;

  logic            load;
  logic            pick_vld;
  logic [2:0]      pick_idx;
  logic [7:0]      pick_pat;
  logic [NDIG-1:0] pick_oh;

  // returns {err, hex}; blank and any non-glyph pattern report err with hex 0
  function automatic logic [4:0] glyph(input logic [6:0] p);
    case (p)
      7'h7E:   glyph = 5'h00;
      7'h30:   glyph = 5'h01;
      7'h6D:   glyph = 5'h02;
      7'h79:   glyph = 5'h03;
      7'h33:   glyph = 5'h04;
      7'h5B:   glyph = 5'h05;
      7'h5F:   glyph = 5'h06;
      7'h70:   glyph = 5'h07;
      7'h7F:   glyph = 5'h08;
      7'h7B:   glyph = 5'h09;
      7'h77:   glyph = 5'h0A;
      7'h1F:   glyph = 5'h0B;
      7'h4E:   glyph = 5'h0C;
      7'h3D:   glyph = 5'h0D;
      7'h4F:   glyph = 5'h0E;
      7'h47:   glyph = 5'h0F;
      default: glyph = 5'h10;
    endcase
  endfunction

  always_comb begin
    raw = ~i_seg;
`ifndef SEG_DP_EN
    raw[0] = 1'b0;
`endif
    sel     = ~i_dig;
    sel_vld = $onehot(sel);
  end

  always_comb begin
    for (int d = 0; d < NDIG; d++) begin
      if (raw == cand_q[d]) begin
        cnt_upd[d] = (cnt_q[d] >= STABLE_C) ? STABLE_C : cnt_q[d] + 4'd1;
      end else begin
        cnt_upd[d] = 4'd1;
      end
      commit[d] = sel_vld && sel[d] && (cnt_upd[d] == STABLE_C) && (raw != comm_q[d]);
    end
  end

  // descending scan so the lowest dirty index wins
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = 3'd0;
    pick_pat = 8'h00;
    pick_oh  = '0;
    for (int d = NDIG - 1; d >= 0; d--) begin
      if (dirty_q[d]) begin
        pick_vld   = 1'b1;
        pick_idx   = 3'(d);
        pick_pat   = comm_q[d];
        pick_oh    = '0;
        pick_oh[d] = 1'b1;
      end
    end
  end

  assign load = !o_vld || i_rdy;

  // a commit landing on the digit being loaded keeps it dirty so the newer value follows
  always_comb begin
    dirty_nxt = dirty_q;
    if (load) dirty_nxt = dirty_nxt & ~pick_oh;
    dirty_nxt = dirty_nxt | commit;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int d = 0; d < NDIG; d++) begin
        cand_q[d] <= 8'h00;
        cnt_q[d]  <= 4'd0;
        comm_q[d] <= 8'h00;
      end
      dirty_q <= '0;
      o_vld   <= 1'b0;
      o_idx   <= 3'd0;
      o_hex   <= 4'd0;
      o_err   <= 1'b0;
      o_dp    <= 1'b0;
    end else begin
      for (int d = 0; d < NDIG; d++) begin
        if (sel_vld && sel[d]) begin
          cand_q[d] <= raw;
          cnt_q[d]  <= cnt_upd[d];
          if (commit[d]) comm_q[d] <= raw;
        end
      end
      dirty_q <= dirty_nxt;
      if (load) begin
        o_vld <= pick_vld;
        if (pick_vld) begin
          o_idx          <= pick_idx;
          {o_err, o_hex} <= glyph(pick_pat[7:1]);
          o_dp           <= pick_pat[0];
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decode.sv
// Self-checking bench for seg_scan_decode: directed scenarios plus randomized traffic against a window-based model.
module tb_seg_scan_decode;

  localparam int NDIG   = 2;
  localparam int STABLE = 4;
  localparam logic [1:0] DIG0 = 2'b10;
  localparam logic [1:0] DIG1 = 2'b01;
  localparam logic [1:0] NONE = 2'b11;
  localparam logic [1:0] BOTH = 2'b00;

  logic            clk = 1'b0;
  logic            rst;
  logic [7:0]      seg;
  logic [NDIG-1:0] dig;
  logic            rdy;
  logic            vld;
  logic [2:0]      idx;
  logic [3:0]      hex;
  logic            err;
  logic            dp;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seg_scan_decode #(.NDIG(NDIG), .STABLE(STABLE)) dut (
    .clk(clk), .rst(rst), .i_seg(seg), .i_dig(dig),
    .o_vld(vld), .i_rdy(rdy), .o_idx(idx), .o_hex(hex), .o_err(err), .o_dp(dp)
  );

  logic [6:0] glyph_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                 7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  // reference model: last STABLE selected samples per digit, committed pattern, pending flags
  logic [7:0] m_win  [NDIG][STABLE];
  int         m_nsamp [NDIG];
  logic [7:0] m_comm [NDIG];
  bit         m_dirty [NDIG];
  bit         m_vld;
  int         m_idx;
  logic [7:0] m_pat;

  function automatic logic [4:0] exp_glyph(input logic [7:0] p);
    for (int i = 0; i < 16; i++) if (glyph_tab[i] == p[7:1]) return {1'b0, 4'(i)};
    return 5'h10;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < NDIG; d++) begin
      m_nsamp[d] = 0;
      m_comm[d]  = 8'h00;
      m_dirty[d] = 1'b0;
    end
    m_vld = 1'b0;
    m_idx = 0;
    m_pat = 8'h00;
  endtask

  task automatic model_step();
    logic [7:0] raw;
    int sd;
    int cd;
    bit same;
    if (!rst) begin
      model_reset();
      return;
    end
    raw = ~seg;
`ifndef SEG_DP_EN
    raw[0] = 1'b0;
`endif
    sd = -1;
    cd = -1;
    if ($countones(~dig) == 1) for (int d = 0; d < NDIG; d++) if (!dig[d]) sd = d;
    if (sd >= 0) begin
      for (int k = STABLE - 1; k > 0; k--) m_win[sd][k] = m_win[sd][k-1];
      m_win[sd][0] = raw;
      m_nsamp[sd]++;
      same = 1'b1;
      for (int k = 0; k < STABLE; k++) if (m_win[sd][k] != raw) same = 1'b0;
      if (m_nsamp[sd] >= STABLE && same && raw != m_comm[sd]) cd = sd;
    end
    if (!m_vld || rdy) begin
      m_vld = 1'b0;
      for (int d = 0; d < NDIG && !m_vld; d++) begin
        if (m_dirty[d]) begin
          m_vld      = 1'b1;
          m_idx      = d;
          m_pat      = m_comm[d];
          m_dirty[d] = 1'b0;
        end
      end
    end
    if (cd >= 0) begin
      m_comm[cd]  = raw;
      m_dirty[cd] = 1'b1;
    end
  endtask

  // inputs change at the falling edge; outputs are read at the next falling edge
  task automatic drive(input logic [1:0] d, input logic [7:0] s, input logic r);
    dig = d;
    seg = s;
    rdy = r;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1;
    n_checks++;
    if ({vld, idx, hex, err, dp} !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_async: got %b want 0", {vld, idx, hex, err, dp});
    end
    drive(NONE, 8'hFF, 1'b0);
    drive(NONE, 8'hFF, 1'b0);
    n_checks++;
    if ({vld, idx, hex, err, dp} !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_hold: got %b want 0", {vld, idx, hex, err, dp});
    end
    rst = 1'b1;
    drive(NONE, 8'hFF, 1'b1);
    n_checks++;
    if (vld !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_vld: got %b want 0", vld);
    end
  endtask

  task automatic test_basic();
    for (int i = 0; i < 4; i++) begin
      drive(DIG0, ~8'hDA, 1'b1);
      n_checks++;
      if (vld !== 1'b0) begin
        n_fail++;
        $display("FAIL basic_early sample %0d: got vld %b want 0", i, vld);
      end
    end
    drive(NONE, 8'hFF, 1'b1);
    n_checks++;
    if ({vld, idx, hex, err, dp} !== {1'b1, 3'd0, 4'd2, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL basic_event: got vld%b idx%0d hex%h err%b dp%b want 1 0 2 0 0", vld, idx, hex, err, dp);
    end
    drive(NONE, 8'hFF, 1'b1);
    n_checks++;
    if (vld !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_drop: got %b want 0", vld);
    end
  endtask

  task automatic test_debounce();
    logic [7:0] pats [8] = '{~8'hF2, ~8'hF2, ~8'hF2, ~8'h60, ~8'hF2, ~8'hF2, ~8'hF2, ~8'hF2};
    for (int i = 0; i < 8; i++) begin
      drive(DIG1, pats[i], 1'b1);
      n_checks++;
      if (vld !== 1'b0) begin
        n_fail++;
        $display("FAIL debounce_quiet step %0d: got vld %b want 0", i, vld);
      end
    end
    drive(NONE, 8'hFF, 1'b1);
    n_checks++;
    if ({vld, idx, hex, err} !== {1'b1, 3'd1, 4'd3, 1'b0}) begin
      n_fail++;
      $display("FAIL debounce_event: got vld%b idx%0d hex%h err%b want 1 1 3 0", vld, idx, hex, err);
    end
    drive(NONE, 8'hFF, 1'b1);
    n_checks++;
    if (vld !== 1'b0) begin
      n_fail++;
      $display("FAIL debounce_single: got vld %b want 0", vld);
    end
  endtask

  task automatic test_invalid();
    for (int i = 0; i < 4; i++) drive(DIG0, ~8'h02, 1'b1);
    drive(NONE, 8'hFF, 1'b1);
    n_checks++;
    if ({vld, idx, hex, err} !== {1'b1, 3'd0, 4'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL invalid_err: got vld%b idx%0d hex%h err%b want 1 0 0 1", vld, idx, hex, err);
    end
    drive(NONE, 8'hFF, 1'b1);
    for (int i = 0; i < 4; i++) drive(DIG0, ~8'hFC, 1'b1);
    drive(NONE, 8'hFF, 1'b1);
    n_checks++;
    if ({vld, idx, hex, err} !== {1'b1, 3'd0, 4'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL invalid_zero: got vld%b idx%0d hex%h err%b want 1 0 0 0", vld, idx, hex, err);
    end
    drive(NONE, 8'hFF, 1'b1);
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 4; i++) drive(DIG1, ~8'hEE, 1'b0);
    for (int i = 0; i < 4; i++) drive(DIG0, ~8'hB6, 1'b0);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({vld, idx, hex} !== {1'b1, 3'd1, 4'hA}) begin
        n_fail++;
        $display("FAIL bp_hold %0d: got vld%b idx%0d hex%h want 1 1 a", i, vld, idx, hex);
      end
      drive(NONE, 8'hFF, 1'b0);
    end
    drive(NONE, 8'hFF, 1'b1);
    n_checks++;
    if ({vld, idx, hex} !== {1'b1, 3'd0, 4'h5}) begin
      n_fail++;
      $display("FAIL bp_second: got vld%b idx%0d hex%h want 1 0 5", vld, idx, hex);
    end
    drive(NONE, 8'hFF, 1'b1);
    n_checks++;
    if (vld !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_drop: got %b want 0", vld);
    end
  endtask

  task automatic test_glitch_reset();
    logic [1:0] gd [7] = '{DIG0, DIG0, BOTH, NONE, BOTH, DIG0, DIG0};
    logic [7:0] gs [7] = '{~8'h66, ~8'h66, ~8'h66, ~8'h66, ~8'h00, ~8'h66, ~8'h66};
    for (int i = 0; i < 7; i++) begin
      drive(gd[i], gs[i], 1'b1);
      n_checks++;
      if (vld !== 1'b0) begin
        n_fail++;
        $display("FAIL glitch_quiet step %0d: got vld %b want 0", i, vld);
      end
    end
    drive(NONE, 8'hFF, 1'b1);
    n_checks++;
    if ({vld, idx, hex} !== {1'b1, 3'd0, 4'd4}) begin
      n_fail++;
      $display("FAIL glitch_event: got vld%b idx%0d hex%h want 1 0 4", vld, idx, hex);
    end
    drive(NONE, 8'hFF, 1'b1);
    // build a pending event plus a partial count, then reset between edges
    for (int i = 0; i < 4; i++) drive(DIG1, ~8'hB6, 1'b0);
    drive(NONE, 8'hFF, 1'b0);
    drive(DIG0, ~8'hE0, 1'b0);
    drive(DIG0, ~8'hE0, 1'b0);
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({vld, idx, hex} !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_mid: got vld%b idx%0d hex%h want 0 0 0", vld, idx, hex);
    end
    drive(NONE, 8'hFF, 1'b1);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) drive(DIG0, ~8'hE0, 1'b1);
    drive(NONE, 8'hFF, 1'b1);
    n_checks++;
    if (vld !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_fresh: got vld %b want 0", vld);
    end
    drive(DIG0, ~8'hE0, 1'b1);
    drive(NONE, 8'hFF, 1'b1);
    n_checks++;
    if ({vld, idx, hex} !== {1'b1, 3'd0, 4'd7}) begin
      n_fail++;
      $display("FAIL reset_recount: got vld%b idx%0d hex%h want 1 0 7", vld, idx, hex);
    end
    drive(NONE, 8'hFF, 1'b1);
  endtask

  task automatic test_dp();
    for (int i = 0; i < 4; i++) drive(DIG0, ~8'hE1, 1'b1);
    drive(NONE, 8'hFF, 1'b1);
`ifdef SEG_DP_EN
    n_checks++;
    if ({vld, idx, hex, dp} !== {1'b1, 3'd0, 4'd7, 1'b1}) begin
      n_fail++;
      $display("FAIL dp_event: got vld%b idx%0d hex%h dp%b want 1 0 7 1", vld, idx, hex, dp);
    end
`else
    n_checks++;
    if (vld !== 1'b0) begin
      n_fail++;
      $display("FAIL dp_masked: got vld %b want 0", vld);
    end
`endif
    drive(NONE, 8'hFF, 1'b1);
  endtask

  task automatic test_random();
    logic [7:0] cur [NDIG];
    logic [1:0] dsel;
    logic [4:0] g;
    int d;
    int k;
    for (int i = 0; i < NDIG; i++) cur[i] = 8'h00;
    for (int c = 0; c < 1500; c++) begin
      d = int'($urandom_range(0, NDIG - 1));
      if ($urandom_range(0, 5) == 0) begin
        k = int'($urandom_range(0, 19));
        case (k)
          16:      cur[d] = 8'h00;
          17:      cur[d] = 8'h02;
          18:      cur[d] = 8'h92;
          19:      cur[d] = 8'hFE;
          default: cur[d] = {glyph_tab[k], 1'b0};
        endcase
        if ($urandom_range(0, 3) == 0) cur[d][0] = ~cur[d][0];
      end
      case ($urandom_range(0, 9))
        8:       dsel = NONE;
        9:       dsel = BOTH;
        default: dsel = ~(2'b01 << d);
      endcase
      drive(dsel, ~cur[d], $urandom_range(0, 3) != 0);
      n_checks++;
      if (vld !== m_vld) begin
        n_fail++;
        $display("FAIL rand_vld cycle %0d: got %b want %b", c, vld, m_vld);
      end
      if (m_vld) begin
        g = exp_glyph(m_pat);
        n_checks++;
        if ({idx, err, hex, dp} !== {3'(m_idx), g, m_pat[0]}) begin
          n_fail++;
          $display("FAIL rand_evt cycle %0d: got idx%0d err%b hex%h dp%b want idx%0d err%b hex%h dp%b",
                   c, idx, err, hex, dp, m_idx, g[4], g[3:0], m_pat[0]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    dig = NONE;
    seg = 8'hFF;
    rdy = 1'b0;
    model_reset();
    test_reset();
    test_basic();
    test_debounce();
    test_invalid();
    test_backpressure();
    test_glitch_reset();
    test_dp();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
